// File: rtl/muldiv_pkg.sv
// Shared op encodings, FSM states and op-class helpers
// for the EX-stage multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'b000,
    MD_MULTU = 3'b001,
    MD_DIV   = 3'b010,
    MD_DIVU  = 3'b011,
    MD_MADD  = 3'b100,
    MD_MADDU = 3'b101,
    MD_MSUB  = 3'b110,
    MD_MSUBU = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } md_state_e;

  function automatic logic is_signed(logic [2:0] op);
    return ~op[0];
  endfunction

  function automatic logic is_div(logic [2:0] op);
    return op[2:1] == 2'b01;
  endfunction

  function automatic logic is_acc(logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic is_sub(logic [2:0] op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/muldiv_divider.sv
// Iterative restoring radix-2 divider on magnitudes,
// one quotient bit per step, sign fixup on the outputs.
module muldiv_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             init,
  input  logic             step,
  input  logic             sgn,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [CW-1:0]    cnt_q;
  logic             negq_q;
  logic             negr_q;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH:0]   trial;

  assign a_neg = sgn & dividend[WIDTH-1];
  assign b_neg = sgn & divisor[WIDTH-1];
  assign a_abs = a_neg ? -dividend : dividend;
  assign b_abs = b_neg ? -divisor : divisor;

  // shifted partial remainder minus divisor; borrow bit decides
  assign trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
    end else if (init) begin
      rem_q  <= '0;
      quo_q  <= a_abs;
      dvs_q  <= b_abs;
      cnt_q  <= '0;
      negq_q <= a_neg ^ b_neg;
      negr_q <= a_neg;
    end else if (step) begin
      if (!trial[WIDTH]) begin
        rem_q <= trial[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_q <= {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
      end
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign done = cnt_q == CW'(WIDTH);
  assign quo  = negq_q ? -quo_q : quo_q;
  assign rem  = negr_q ? -rem_q : rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/DIV/MADD/MSUB unit producing HI/LO
// behind a start/valid handshake with an EX stall output.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start_i,
  input  logic [2:0]         op_i,
  input  logic [WIDTH-1:0]   op1_i,
  input  logic [WIDTH-1:0]   op2_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic               annul_i,
  output logic               busy_o,
  output logic               valid_o,
  output logic [WIDTH-1:0]   hi_o,
  output logic [WIDTH-1:0]   lo_o
);

  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  md_state_e state_q, state_d;

  logic               accept;
  logic               div_zero;
  logic               div_init;
  logic               div_step;
  logic               div_done;
  logic [WIDTH-1:0]   div_quo;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] mul_res;
  logic [2*WIDTH-1:0] pipe_q [MUL_LAT];
  logic [CW-1:0]      cnt_q;
  logic               mul_last;

  assign accept   = (state_q == S_IDLE) & start_i & ~annul_i;
  assign div_zero = op2_i == '0;
  assign div_init = accept & is_div(op_i) & ~div_zero;
  assign div_step = (state_q == S_DIV) & ~div_done;
  assign mul_last = cnt_q == CW'(MUL_LAT - 1);

  // sign/zero-extended full product, truncation gives mod 2^(2W)
  assign a_ext = {{WIDTH{is_signed(op_i) & op1_i[WIDTH-1]}}, op1_i};
  assign b_ext = {{WIDTH{is_signed(op_i) & op2_i[WIDTH-1]}}, op2_i};
  assign prod  = a_ext * b_ext;

  always_comb begin
    mul_res = prod;
    if (is_acc(op_i))
      mul_res = is_sub(op_i) ? acc_i - prod : acc_i + prod;
  end

  muldiv_divider #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .resetn   (resetn),
    .init     (div_init),
    .step     (div_step),
    .sgn      (is_signed(op_i)),
    .dividend (op1_i),
    .divisor  (op2_i),
    .done     (div_done),
    .quo      (div_quo),
    .rem      (div_rem)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!is_div(op_i)) state_d = S_MUL;
          else if (div_zero) state_d = S_DONE;
          else               state_d = S_DIV;
        end
      end
      S_MUL: begin
        if (annul_i)       state_d = S_IDLE;
        else if (mul_last) state_d = S_DONE;
      end
      S_DIV: begin
        if (annul_i)       state_d = S_IDLE;
        else if (div_done) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_o  <= '0;
      lo_o  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < MUL_LAT; i++) pipe_q[i] <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            cnt_q     <= '0;
            pipe_q[0] <= mul_res;
            if (is_div(op_i) && div_zero) begin
              hi_o <= op1_i;
              lo_o <= '1;
            end
          end
        end
        S_MUL: begin
          cnt_q <= cnt_q + CW'(1);
          for (int i = 1; i < MUL_LAT; i++) pipe_q[i] <= pipe_q[i-1];
          if (mul_last && !annul_i)
            {hi_o, lo_o} <= pipe_q[MUL_LAT-1];
        end
        S_DIV: begin
          if (div_done && !annul_i) begin
            hi_o <= div_rem;
            lo_o <= div_quo;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o  = (state_q == S_MUL) | (state_q == S_DIV);
  assign valid_o = state_q == S_DONE;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed checks of muldiv_unit at 32-bit/MUL_LAT=2
// and at 16-bit/MUL_LAT=1.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;

  logic        start_i = 1'b0;
  logic [2:0]  op_i = '0;
  logic [31:0] op1_i = '0;
  logic [31:0] op2_i = '0;
  logic [63:0] acc_i = '0;
  logic        annul_i = 1'b0;
  logic        busy_o;
  logic        valid_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  logic        start16 = 1'b0;
  logic [2:0]  op16 = '0;
  logic [15:0] a16 = '0;
  logic [15:0] b16 = '0;
  logic [31:0] acc16 = '0;
  logic        annul16 = 1'b0;
  logic        busy16;
  logic        valid16;
  logic [15:0] hi16;
  logic [15:0] lo16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32), .MUL_LAT(2)) u_dut (
    .clk     (clk),
    .resetn  (resetn),
    .start_i (start_i),
    .op_i    (op_i),
    .op1_i   (op1_i),
    .op2_i   (op2_i),
    .acc_i   (acc_i),
    .annul_i (annul_i),
    .busy_o  (busy_o),
    .valid_o (valid_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  muldiv_unit #(.WIDTH(16), .MUL_LAT(1)) u_dut16 (
    .clk     (clk),
    .resetn  (resetn),
    .start_i (start16),
    .op_i    (op16),
    .op1_i   (a16),
    .op2_i   (b16),
    .acc_i   (acc16),
    .annul_i (annul16),
    .busy_o  (busy16),
    .valid_o (valid16),
    .hi_o    (hi16),
    .lo_o    (lo16)
  );

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run32(string tag, md_op_e op, logic [31:0] a,
                       logic [31:0] b, logic [63:0] acc, int exp_cyc,
                       logic [31:0] exp_hi, logic [31:0] exp_lo,
                       logic hold);
    int   cyc;
    logic bok;
    op_i = op; op1_i = a; op2_i = b; acc_i = acc; start_i = 1'b1;
    @(posedge clk); #1;
    if (hold) begin
      op_i = MD_MULT; op1_i = 32'd1; op2_i = 32'd1;
    end else begin
      start_i = 1'b0;
    end
    cyc = 1;
    bok = 1'b1;
    while (cyc < 64) begin
      if (valid_o) break;
      bok &= busy_o;
      @(posedge clk); #1;
      cyc++;
    end
    start_i = 1'b0;
    chk({tag, ".cyc"}, 64'(cyc), 64'(exp_cyc));
    chk({tag, ".busy"}, 64'({bok, busy_o}), 64'(2'b10));
    chk({tag, ".hi"}, 64'(hi_o), 64'(exp_hi));
    chk({tag, ".lo"}, 64'(lo_o), 64'(exp_lo));
    @(posedge clk); #1;
    chk({tag, ".pulse"}, 64'(valid_o), 64'(0));
    chk({tag, ".hold"}, {hi_o, lo_o}, {exp_hi, exp_lo});
  endtask

  task automatic run16(string tag, md_op_e op, logic [15:0] a,
                       logic [15:0] b, int exp_cyc,
                       logic [15:0] exp_hi, logic [15:0] exp_lo);
    int cyc;
    op16 = op; a16 = a; b16 = b; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    cyc = 1;
    while (cyc < 40) begin
      if (valid16) break;
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, ".cyc"}, 64'(cyc), 64'(exp_cyc));
    chk({tag, ".hilo"}, 64'({hi16, lo16}), 64'({exp_hi, exp_lo}));
    @(posedge clk); #1;
  endtask

  initial begin
    int nval;
    #12;
    chk("rst32", 64'({busy_o, valid_o, hi_o, lo_o}), 64'(0));
    chk("rst16", 64'({busy16, valid16, hi16, lo16}), 64'(0));
    resetn = 1'b1;
    @(posedge clk); #1;

    run32("mult",  MD_MULT,  32'hFFFFFFFD, 32'd7, 64'd0, 3,
          32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    run32("multu", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd0, 3,
          32'hFFFFFFFE, 32'h00000001, 1'b0);
    run32("div",   MD_DIV,   32'hFFFFFFF9, 32'd2, 64'd0, 34,
          32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run32("divu",  MD_DIVU,  32'hFFFFFFF9, 32'd2, 64'd0, 34,
          32'h00000001, 32'h7FFFFFFC, 1'b0);
    run32("divneg", MD_DIV,  32'd7, 32'hFFFFFFFE, 64'd0, 34,
          32'h00000001, 32'hFFFFFFFD, 1'b0);
    run32("divmin", MD_DIV,  32'h80000000, 32'hFFFFFFFF, 64'd0, 34,
          32'h00000000, 32'h80000000, 1'b0);
    run32("divu0", MD_DIVU,  32'd5, 32'd0, 64'd0, 1,
          32'h00000005, 32'hFFFFFFFF, 1'b0);
    run32("div0",  MD_DIV,   32'hFFFFFFF9, 32'd0, 64'd0, 1,
          32'hFFFFFFF9, 32'hFFFFFFFF, 1'b0);
    run32("maddu", MD_MADDU, 32'd2, 32'd3, 64'h00000001_FFFFFFFF, 3,
          32'h00000002, 32'h00000005, 1'b0);
    run32("madd",  MD_MADD,  32'hFFFFFFFE, 32'd3, 64'd10, 3,
          32'h00000000, 32'h00000004, 1'b0);
    run32("msub",  MD_MSUB,  32'd1, 32'd1, 64'd0, 3,
          32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    run32("msubu", MD_MSUBU, 32'h80000000, 32'd2, 64'h00000001_00000000, 3,
          32'h00000000, 32'h00000000, 1'b0);
    run32("hold",  MD_DIV,   32'd20, 32'd3, 64'd0, 34,
          32'h00000002, 32'h00000006, 1'b1);

    // abort a divide in flight
    op_i = MD_DIVU; op1_i = 32'd100; op2_i = 32'd7; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    annul_i = 1'b1;
    @(posedge clk); #1;
    annul_i = 1'b0;
    chk("annul.state", 64'({busy_o, valid_o}), 64'(0));
    chk("annul.out", {hi_o, lo_o}, 64'h00000002_00000006);
    nval = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (valid_o || busy_o) nval++;
    end
    chk("annul.novalid", 64'(nval), 64'(0));

    // annul in IDLE blocks a start
    op_i = MD_MULT; op1_i = 32'd4; op2_i = 32'd4; start_i = 1'b1;
    annul_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; annul_i = 1'b0;
    chk("annul.idle", 64'({busy_o, valid_o}), 64'(0));

    // asynchronous reset mid-divide
    op_i = MD_DIV; op1_i = 32'hFFFFFFF9; op2_i = 32'd2; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("rst.busy_before", 64'(busy_o), 64'(1));
    resetn = 1'b0;
    #1;
    chk("rst.mid", 64'({busy_o, valid_o, hi_o, lo_o}), 64'(0));
    #1;
    resetn = 1'b1;
    nval = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (valid_o || busy_o) nval++;
    end
    chk("rst.discard", 64'(nval), 64'(0));

    run32("after", MD_MULTU, 32'd6, 32'd7, 64'd0, 3,
          32'h00000000, 32'h0000002A, 1'b0);

    run16("w16mult", MD_MULT, 16'd100, 16'hFFFD, 2, 16'hFFFF, 16'hFED4);
    run16("w16div",  MD_DIV,  16'hFF9C, 16'd7, 18, 16'hFFFE, 16'hFFF2);
    run16("w16min",  MD_DIV,  16'h8000, 16'hFFFF, 18, 16'h0000, 16'h8000);
    run16("w16divu", MD_DIVU, 16'h8000, 16'hFFFF, 18, 16'h8000, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
